// File: rtl/bias_relu_quant.sv
// Bias add, ReLU and shift/saturate requantisation of accumulated columns, with an output FIFO.
// Define BRQ_ROUND_EN for round-half-up before the shift; the default build truncates.
module bias_relu_quant #(
  parameter int unsigned DW         = 32,
  parameter int unsigned HIT        = 56,
  parameter int unsigned WID        = 56,
  parameter int unsigned OCH        = 64,
  parameter int unsigned OW         = 8,
  parameter int unsigned SHIFT_W    = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW*HIT-1:0]        data_i,
  input  logic                     valid_i,
  input  logic                     bias_we,
  input  logic [$clog2(OCH)-1:0]   bias_addr,
  input  logic [DW-1:0]            bias_wdata,
  input  logic [SHIFT_W-1:0]       shift_amt,
  input  logic                     ovf_clr,
  output logic [OW*HIT-1:0]        data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(WID)-1:0]   col_idx_o,
  output logic [$clog2(OCH)-1:0]   och_idx_o,
  output logic                     ovf_o
);

  localparam int unsigned CW   = $clog2(WID);
  localparam int unsigned OCW  = $clog2(OCH);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;

  // Non-negative sum -> shifted, saturated activation; negative sums clamp to zero.
  function automatic logic [OW-1:0] quant(input logic signed [DW:0] sum,
                                          input logic [SHIFT_W-1:0] sh);
    logic [DW+1:0] ext;
    logic [DW+1:0] q;
    if (sum[DW]) return '0;
    ext = {1'b0, sum};
`ifdef BRQ_ROUND_EN
    if (sh != '0) ext = ext + ((DW+2)'(1) << (sh - SHIFT_W'(1)));
`endif
    q = ext >> sh;
    if (|q[DW+1:OW]) return '1;
    return q[OW-1:0];
  endfunction

  logic [CW-1:0]           col_cnt_q, col_cnt_d;
  logic [OCW-1:0]          och_cnt_q, och_cnt_d;
  logic [DW-1:0]           bias_q [OCH];
  logic [DW-1:0]           bias_rd;
  logic [SHIFT_W-1:0]      sh_eff;

  logic                    s1_valid_q;
  logic [CW-1:0]           s1_col_q;
  logic [OCW-1:0]          s1_och_q;
  logic signed [DW:0]      s1_sum_d [HIT];
  logic signed [DW:0]      s1_sum_q [HIT];

  logic                    s2_valid_q;
  logic [CW-1:0]           s2_col_q;
  logic [OCW-1:0]          s2_och_q;
  logic [OW*HIT-1:0]       s2_data_d, s2_data_q;

  logic [OW*HIT-1:0]       mem_data_q [FIFO_DEPTH];
  logic [CW-1:0]           mem_col_q  [FIFO_DEPTH];
  logic [OCW-1:0]          mem_och_q  [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]         count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    push, pop, full, drop;

  // Column/channel position: channel advances when the column index wraps.
  always_comb begin
    col_cnt_d = col_cnt_q;
    och_cnt_d = och_cnt_q;
    if (valid_i) begin
      if (col_cnt_q == CW'(WID - 1)) begin
        col_cnt_d = '0;
        och_cnt_d = (och_cnt_q == OCW'(OCH - 1)) ? '0 : och_cnt_q + OCW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bias_we) bias_q[bias_addr] <= bias_wdata;
  end

  assign bias_rd = bias_q[och_cnt_q];
  assign sh_eff  = (shift_amt > SHIFT_W'(DW)) ? SHIFT_W'(DW) : shift_amt;

  always_comb begin
    for (int unsigned k = 0; k < HIT; k++) begin
      s1_sum_d[k] = $signed({data_i[DW*k+DW-1], data_i[DW*k +: DW]})
                  + $signed({bias_rd[DW-1], bias_rd});
    end
  end

  always_comb begin
    s2_data_d = '0;
    for (int unsigned k = 0; k < HIT; k++) begin
      s2_data_d[OW*k +: OW] = quant(s1_sum_q[k], sh_eff);
    end
  end

  // Datapath registers carry no reset; only the valids qualify them.
  always_ff @(posedge clk) begin
    if (valid_i) s1_sum_q <= s1_sum_d;
    if (s1_valid_q) s2_data_q <= s2_data_d;
    if (push) begin
      mem_data_q[wr_ptr_q] <= s2_data_q;
      mem_col_q[wr_ptr_q]  <= s2_col_q;
      mem_och_q[wr_ptr_q]  <= s2_och_q;
    end
  end

  // A write into a full FIFO survives only if the head pops on the same edge.
  always_comb begin
    pop      = (count_q != '0) && ready_i;
    full     = (count_q == CNTW'(FIFO_DEPTH));
    push     = s2_valid_q && (!full || pop);
    drop     = s2_valid_q && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CNTW'(push) - CNTW'(pop);
    ovf_d    = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q  <= '0;
      och_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_col_q   <= '0;
      s1_och_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_col_q   <= '0;
      s2_och_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      och_cnt_q  <= och_cnt_d;
      s1_valid_q <= valid_i;
      s1_col_q   <= col_cnt_q;
      s1_och_q   <= och_cnt_q;
      s2_valid_q <= s1_valid_q;
      s2_col_q   <= s1_col_q;
      s2_och_q   <= s1_och_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // First-word-fall-through head, forced to zero while empty.
  assign valid_o   = (count_q != '0);
  assign data_o    = valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign col_idx_o = valid_o ? mem_col_q[rd_ptr_q]  : '0;
  assign och_idx_o = valid_o ? mem_och_q[rd_ptr_q]  : '0;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_bias_relu_quant.sv
// Directed self-checking bench for bias_relu_quant (default parameters).
module tb_bias_relu_quant;

  localparam int unsigned DW = 32, HIT = 56, WID = 56, OCH = 64, OW = 8;
  localparam int unsigned SHIFT_W = 6, FIFO_DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW*HIT-1:0]      data_i;
  logic                   valid_i;
  logic                   bias_we;
  logic [$clog2(OCH)-1:0] bias_addr;
  logic [DW-1:0]          bias_wdata;
  logic [SHIFT_W-1:0]     shift_amt;
  logic                   ovf_clr;
  logic [OW*HIT-1:0]      data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [$clog2(WID)-1:0] col_idx_o;
  logic [$clog2(OCH)-1:0] och_idx_o;
  logic                   ovf_o;

  int n_cmp = 0;
  int n_err = 0;

  bias_relu_quant #(
    .DW(DW), .HIT(HIT), .WID(WID), .OCH(OCH), .OW(OW),
    .SHIFT_W(SHIFT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
    .shift_amt(shift_amt), .ovf_clr(ovf_clr), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .col_idx_o(col_idx_o),
    .och_idx_o(och_idx_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] pix(input int k);
    return data_o[OW*k +: OW];
  endfunction

  task automatic set_pix(input int k, input int v);
    data_i[DW*k +: DW] = DW'(v);
  endtask

  task automatic write_bias(input int idx, input int v);
    bias_we = 1'b1; bias_addr = 6'(idx); bias_wdata = DW'(v);
    tick();
    bias_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
  endtask

  // One column in, then wait until it sits at the FIFO head (empty FIFO).
  task automatic run_col(input string tag);
    valid_i = 1'b1; tick(); valid_i = 1'b0;
    tick();
    check_eq({tag, "_early"}, 64'(valid_o), 64'd0);
    tick();
    check_eq({tag, "_valid"}, 64'(valid_o), 64'd1);
  endtask

  logic [OW*HIT-1:0] exp_col;
  int j;

  initial begin
    rst = 1'b1; data_i = '0; valid_i = 0; bias_we = 0; bias_addr = '0;
    bias_wdata = '0; shift_amt = '0; ovf_clr = 0; ready_i = 1;
    #12;
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_data", 64'(data_o == '0), 64'd1);
    check_eq("rst_col", 64'(col_idx_o), 64'd0);
    check_eq("rst_och", 64'(och_idx_o), 64'd0);
    check_eq("rst_ovf", 64'(ovf_o), 64'd0);
    tick(); rst = 1'b0; tick();

    // Basic: bias 100, all pixels 20, shift 0
    write_bias(0, 100);
    for (int k = 0; k < HIT; k++) set_pix(k, 20);
    run_col("basic");
    for (int k = 0; k < HIT; k++) exp_col[OW*k +: OW] = 8'd120;
    check_eq("basic_all", 64'(data_o == exp_col), 64'd1);
    check_eq("basic_p0", 64'(pix(0)), 64'd120);
    check_eq("basic_p55", 64'(pix(55)), 64'd120);
    check_eq("basic_col", 64'(col_idx_o), 64'd0);
    check_eq("basic_och", 64'(och_idx_o), 64'd0);
    tick();
    check_eq("basic_pop", 64'(valid_o), 64'd0);

    // ReLU with negative bias
    do_reset();
    write_bias(0, -50);
    data_i = '0;
    set_pix(0, 30); set_pix(1, 80); set_pix(2, 1000);
    run_col("relu");
    check_eq("relu_p0", 64'(pix(0)), 64'd0);
    check_eq("relu_p1", 64'(pix(1)), 64'd30);
    check_eq("relu_p2", 64'(pix(2)), 64'd255);
    check_eq("relu_p3", 64'(pix(3)), 64'd0);
    tick();

    // Shift 2 and saturation boundary
    write_bias(0, 0);
    shift_amt = 6'd2;
    data_i = '0;
    set_pix(0, 1000); set_pix(1, 2000); set_pix(2, 1023); set_pix(3, 1024); set_pix(4, -5);
    run_col("sh2");
    check_eq("sh2_p0", 64'(pix(0)), 64'd250);
    check_eq("sh2_p1", 64'(pix(1)), 64'd255);
    check_eq("sh2_p2", 64'(pix(2)), 64'd255);
    check_eq("sh2_p3", 64'(pix(3)), 64'd255);
    check_eq("sh2_p4", 64'(pix(4)), 64'd0);
    tick();

    // Shift 3: truncation vs rounding
    shift_amt = 6'd3;
    data_i = '0;
    set_pix(0, 13); set_pix(1, 11); set_pix(2, 12);
    run_col("sh3");
`ifdef BRQ_ROUND_EN
    check_eq("sh3_13", 64'(pix(0)), 64'd2);
    check_eq("sh3_12", 64'(pix(2)), 64'd2);
`else
    check_eq("sh3_13", 64'(pix(0)), 64'd1);
    check_eq("sh3_12", 64'(pix(2)), 64'd1);
`endif
    check_eq("sh3_11", 64'(pix(1)), 64'd1);
    tick();

    // Shift 24 on the extreme accumulator values
    shift_amt = 6'd24;
    data_i = '0;
    set_pix(0, 32'h7FFF_FFFF); set_pix(1, 32'h8000_0000);
    run_col("sh24");
`ifdef BRQ_ROUND_EN
    check_eq("sh24_max", 64'(pix(0)), 64'd128);
`else
    check_eq("sh24_max", 64'(pix(0)), 64'd127);
`endif
    check_eq("sh24_min", 64'(pix(1)), 64'd0);
    tick();

    // Two channels back-to-back with ready high
    do_reset();
    write_bias(0, 7); write_bias(1, -3);
    shift_amt = '0; ready_i = 1'b1; data_i = '0;
    for (int c = 0; c < 2 * WID + 2; c++) begin
      if (c < 2 * WID) begin
        set_pix(0, c); set_pix(55, 5); valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      if (c >= 2) begin
        j = c - 2;
        check_eq("strm_valid", 64'(valid_o), 64'd1);
        check_eq("strm_col", 64'(col_idx_o), 64'(j % WID));
        check_eq("strm_och", 64'(och_idx_o), 64'(j / WID));
        check_eq("strm_p0", 64'(pix(0)), (j < WID) ? 64'(j + 7) : 64'(j - 3));
        check_eq("strm_p55", 64'(pix(55)), (j < WID) ? 64'd12 : 64'd2);
      end
    end
    valid_i = 1'b0;
    tick();
    check_eq("strm_end", 64'(valid_o), 64'd0);

    // Overflow: 6 columns into a 4-deep FIFO with ready low
    do_reset();
    write_bias(0, 0);
    ready_i = 1'b0; data_i = '0;
    for (int c = 0; c < 6; c++) begin
      set_pix(0, 10 + c); valid_i = 1'b1; tick();
    end
    valid_i = 1'b0;
    tick(); tick(); tick();
    check_eq("ovf_set", 64'(ovf_o), 64'd1);
    check_eq("ovf_valid", 64'(valid_o), 64'd1);
    check_eq("ovf_head_col", 64'(col_idx_o), 64'd0);
    tick(); tick();
    check_eq("hold_col", 64'(col_idx_o), 64'd0);
    check_eq("hold_p0", 64'(pix(0)), 64'd10);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", 64'(valid_o), 64'd1);
      check_eq("drain_col", 64'(col_idx_o), 64'(i));
      check_eq("drain_p0", 64'(pix(0)), 64'(10 + i));
      tick();
    end
    check_eq("drain_empty", 64'(valid_o), 64'd0);
    check_eq("ovf_sticky", 64'(ovf_o), 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check_eq("ovf_clr", 64'(ovf_o), 64'd0);

    // Write into a full FIFO with a same-cycle pop: nothing dropped
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_pix(0, 50 + c); valid_i = 1'b1; tick();
    end
    valid_i = 1'b0;
    tick();
    check_eq("fp_head_col", 64'(col_idx_o), 64'd6);
    ready_i = 1'b1;
    tick();
    check_eq("fp_no_ovf", 64'(ovf_o), 64'd0);
    for (int i = 1; i < 5; i++) begin
      check_eq("fp_valid", 64'(valid_o), 64'd1);
      check_eq("fp_col", 64'(col_idx_o), 64'(6 + i));
      check_eq("fp_p0", 64'(pix(0)), 64'(50 + i));
      tick();
    end
    check_eq("fp_empty", 64'(valid_o), 64'd0);

    // Asynchronous reset with columns in flight
    ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_pix(0, 70 + c); valid_i = 1'b1; tick();
    end
    valid_i = 1'b0;
    tick(); tick(); tick();
    check_eq("pre_rst_ovf", 64'(ovf_o), 64'd1);
    for (int c = 0; c < 3; c++) begin
      set_pix(0, 90 + c); valid_i = 1'b1; tick();
    end
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(valid_o), 64'd0);
    check_eq("arst_ovf", 64'(ovf_o), 64'd0);
    check_eq("arst_data", 64'(data_o == '0), 64'd1);
    tick();
    #3 rst = 1'b0;
    ready_i = 1'b1;
    tick(); tick(); tick();
    check_eq("flushed", 64'(valid_o), 64'd0);
    data_i = '0; set_pix(0, 99);
    run_col("post_rst");
    check_eq("post_rst_col", 64'(col_idx_o), 64'd0);
    check_eq("post_rst_och", 64'(och_idx_o), 64'd0);
    check_eq("post_rst_p0", 64'(pix(0)), 64'd99);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
